// File: rtl/rmii_frame_receiver.sv
// RMII receiver: finds preamble/SFD, packs dibits LSB-first into bytes, strobes them out with frame end/error marking.
// Optional FCS check: define RX_CRC_CHECK_EN to add a CRC-32 residue test at end of frame.
module rmii_frame_receiver #(
    parameter int MAX_LEN = 1522,
    parameter int MIN_PRE = 8
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        crs_dv,
    input  logic [1:0]  rx_d,
    input  logic        rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_last,
    output logic        rx_err,
    output logic [10:0] frame_len
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  pre_cnt_reg;
    logic [1:0]  phase_reg;
    logic [5:0]  shift_reg;
    logic [7:0]  held_reg;
    logic        held_valid_reg;
    logic [10:0] byte_cnt_reg;
    logic [10:0] emit_cnt_reg;
    logic        err_reg;
    logic        pend_reg;
    logic        pend_err_reg;
    logic [7:0]  pend_data_reg;
    logic [10:0] pend_len_reg;
    logic [1:0]  since_reg;
    logic [7:0]  rx_data_reg;
    logic        rx_valid_reg;
    logic        rx_last_reg;
    logic        rx_err_reg;
    logic [10:0] frame_len_reg;

    logic        pre_start, byte_done, end_frame, abort;
    logic        crc_bad;
    logic [7:0]  new_byte;
    logic [10:0] emit_inc;
    logic        last_req, fire_last, fire_data, new_err, last_err;
    logic [7:0]  last_data;
    logic [10:0] last_len;

    assign new_byte = {rx_d, shift_reg};
    assign emit_inc = (emit_cnt_reg == 11'h7FF) ? emit_cnt_reg : emit_cnt_reg + 11'd1;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        pre_start  = 1'b0;
        byte_done  = 1'b0;
        end_frame  = 1'b0;
        abort      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (crs_dv && rx_d == 2'b01) begin
                    state_next = PREAMBLE;
                    pre_start  = 1'b1;
                end
            end
            PREAMBLE: begin
                if (!crs_dv)
                    state_next = IDLE;
                else if (rx_er)
                    state_next = DROP;
                else if (rx_d == 2'b11)
                    state_next = (pre_cnt_reg >= 8'(MIN_PRE)) ? DATA : DROP;
                else if (rx_d != 2'b01)
                    state_next = DROP;
            end
            DATA: begin
                if (!crs_dv) begin
                    end_frame  = 1'b1;
                    state_next = IDLE;
                end else if (rx_er) begin
                    abort      = 1'b1;
                    state_next = DROP;
                end else if (phase_reg == 2'd3) begin
                    if (byte_cnt_reg >= 11'(MAX_LEN)) begin
                        abort      = 1'b1;
                        state_next = DROP;
                    end else begin
                        byte_done = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!crs_dv) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The final byte may follow the previous strobe immediately; it is parked
    // until three idle cycles have elapsed so strobe spacing is never violated.
    assign new_err   = err_reg | abort | (end_frame & (phase_reg != 2'd0))
                     | (end_frame & crc_bad) | (emit_inc == 11'd0);
    assign last_req  = pend_reg | ((end_frame | abort) & held_valid_reg);
    assign fire_last = last_req & (since_reg == 2'd3);
    assign fire_data = byte_done & held_valid_reg;
    assign last_data = pend_reg ? pend_data_reg : held_reg;
    assign last_len  = pend_reg ? pend_len_reg : emit_inc;
    assign last_err  = pend_reg ? pend_err_reg : new_err;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pre_cnt_reg    <= 8'd0;
            phase_reg      <= 2'd0;
            shift_reg      <= 6'd0;
            held_reg       <= 8'd0;
            held_valid_reg <= 1'b0;
            byte_cnt_reg   <= 11'd0;
            emit_cnt_reg   <= 11'd0;
            err_reg        <= 1'b0;
            pend_reg       <= 1'b0;
            pend_err_reg   <= 1'b0;
            pend_data_reg  <= 8'd0;
            pend_len_reg   <= 11'd0;
            since_reg      <= 2'd3;
            rx_data_reg    <= 8'd0;
            rx_valid_reg   <= 1'b0;
            rx_last_reg    <= 1'b0;
            rx_err_reg     <= 1'b0;
            frame_len_reg  <= 11'd0;
        end else begin
            if (pre_start) begin
                pre_cnt_reg    <= 8'd1;
                phase_reg      <= 2'd0;
                byte_cnt_reg   <= 11'd0;
                emit_cnt_reg   <= 11'd0;
                held_valid_reg <= 1'b0;
                err_reg        <= 1'b0;
            end else if (state_reg == PREAMBLE && crs_dv && !rx_er && rx_d == 2'b01
                         && pre_cnt_reg != 8'hFF) begin
                pre_cnt_reg <= pre_cnt_reg + 8'd1;
            end

            if (state_reg == DATA && crs_dv && !rx_er) begin
                phase_reg <= phase_reg + 2'd1;
                shift_reg <= {rx_d, shift_reg[5:2]};
            end

            if (byte_done) begin
                held_reg       <= new_byte;
                held_valid_reg <= 1'b1;
                if (byte_cnt_reg != 11'h7FF) byte_cnt_reg <= byte_cnt_reg + 11'd1;
            end
            if (end_frame || abort) held_valid_reg <= 1'b0;
            if (abort) err_reg <= 1'b1;
            if (fire_data) emit_cnt_reg <= emit_inc;

            rx_valid_reg <= fire_data | fire_last;
            rx_last_reg  <= fire_last;
            rx_err_reg   <= fire_last & last_err;
            if (fire_last) begin
                rx_data_reg   <= last_data;
                frame_len_reg <= last_len;
            end else if (fire_data) begin
                rx_data_reg   <= held_reg;
                frame_len_reg <= emit_inc;
            end

            if (fire_last) begin
                pend_reg <= 1'b0;
            end else if (last_req && !pend_reg) begin
                pend_reg      <= 1'b1;
                pend_data_reg <= held_reg;
                pend_len_reg  <= emit_inc;
                pend_err_reg  <= new_err;
            end

            if (fire_data || fire_last)  since_reg <= 2'd0;
            else if (since_reg != 2'd3)  since_reg <= since_reg + 2'd1;
        end
    end

`ifdef RX_CRC_CHECK_EN
    logic [31:0] crc_reg;
    logic [31:0] crc_rev;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)            crc_reg <= 32'hFFFFFFFF;
        else if (pre_start) crc_reg <= 32'hFFFFFFFF;
        else if (byte_done) crc_reg <= crc_byte(crc_reg, new_byte);
    end

    // The reflected register is compared against the residue in normal bit order.
    for (genvar gi = 0; gi < 32; gi++) begin : g_rev
        assign crc_rev[gi] = crc_reg[31-gi];
    end
    assign crc_bad = (crc_rev != 32'hC704DD7B);
`else
    assign crc_bad = 1'b0;
`endif

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign rx_last   = rx_last_reg;
    assign rx_err    = rx_err_reg;
    assign frame_len = frame_len_reg;

endmodule
